// File: rtl/speed_stats_pkg.sv
// Shared bike-computer constants and small helpers for the trip statistics block.
package speed_stats_pkg;

  localparam int SPEED_W      = 7;
  localparam int WIN_LOG2_DEF = 3;

  // Result of evaluating one candidate sample against the running minimum.
  typedef struct packed {
    logic take;
    logic zero;
  } min_eval_t;

  function automatic min_eval_t eval_min(
    input logic [SPEED_W-1:0] sample,
    input logic [SPEED_W-1:0] cur_min,
    input logic               cur_valid,
    input logic               ignore_zero
  );
    min_eval_t res;
    res.zero = (sample == {SPEED_W{1'b0}});
    if (ignore_zero && res.zero) begin
      res.take = 1'b0;
    end else begin
      res.take = ~cur_valid | (sample < cur_min);
    end
    return res;
  endfunction

endpackage

// File: rtl/speed_window.sv
// Sliding window of the last 2^WIN_LOG2 accepted samples with a running sum and fill tracking.
module speed_window
  import speed_stats_pkg::*;
#(
  parameter int WIDTH    = SPEED_W,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      r_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH+WIN_LOG2-1:0] sum,
  output logic                      full
);

  localparam int                DEPTH    = 1 << WIN_LOG2;
  localparam int                SUM_W    = WIDTH + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_MAX = (WIN_LOG2+1)'(DEPTH);
  localparam logic [WIN_LOG2:0] FILL_ONE = (WIN_LOG2+1)'(1);
  localparam logic [WIN_LOG2-1:0] PTR_ONE = WIN_LOG2'(1);

  logic [WIDTH-1:0]    win_r [DEPTH];
  logic [WIN_LOG2-1:0] ptr_r;
  logic [WIN_LOG2:0]   fill_r;
  logic [SUM_W-1:0]    sum_r;
  logic                full_r;
  logic [SUM_W-1:0]    sum_nxt;

  // Next running sum: the oldest entry drops out as the new one comes in, so it cannot underflow.
  always_comb begin
    sum_nxt = sum_r + SUM_W'(din) - SUM_W'(win_r[ptr_r]);
  end

  // Buffer contents, pointer, fill count and sum.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      for (int i = 0; i < DEPTH; i++) win_r[i] <= {WIDTH{1'b0}};
      ptr_r  <= {WIN_LOG2{1'b0}};
      fill_r <= {(WIN_LOG2+1){1'b0}};
      sum_r  <= {SUM_W{1'b0}};
      full_r <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) win_r[i] <= {WIDTH{1'b0}};
      ptr_r  <= {WIN_LOG2{1'b0}};
      fill_r <= {(WIN_LOG2+1){1'b0}};
      sum_r  <= {SUM_W{1'b0}};
      full_r <= 1'b0;
    end else if (push) begin
      win_r[ptr_r] <= din;
      ptr_r        <= ptr_r + PTR_ONE;
      sum_r        <= sum_nxt;
      if (fill_r != FILL_MAX) begin
        fill_r <= fill_r + FILL_ONE;
      end else begin
        fill_r <= fill_r;
      end
      // full tracks the saturated fill count as its own flop so avg_valid is a clean register.
      if (fill_r == FILL_MAX - FILL_ONE) begin
        full_r <= 1'b1;
      end else begin
        full_r <= full_r;
      end
    end else begin
      ptr_r  <= ptr_r;
      fill_r <= fill_r;
      sum_r  <= sum_r;
      full_r <= full_r;
    end
  end

  assign sum  = sum_r;
  assign full = full_r;

endmodule

// File: rtl/speed_stats.sv
// Trip statistics: max speed, min moving speed and windowed average with validity flags.
module speed_stats
  import speed_stats_pkg::*;
#(
  parameter int WIDTH           = SPEED_W,
  parameter int WIN_LOG2        = WIN_LOG2_DEF,
  parameter int IGNORE_ZERO_MIN = 1
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             clr,
  input  logic             freeze,
  input  logic             enable,
  input  logic [WIDTH-1:0] speed,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic             min_valid,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid
);

  localparam int   SUM_W       = WIDTH + WIN_LOG2;
  localparam logic IGNORE_ZERO = (IGNORE_ZERO_MIN != 0);

  logic             push;
  logic [SUM_W-1:0] sum;
  logic             full;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] min_r;
  logic             min_valid_r;
  logic [WIDTH-1:0] max_nxt;
  logic [WIDTH-1:0] min_nxt;
  logic             min_valid_nxt;
  logic             take_min;

  assign push = enable & ~clr & ~freeze;

  speed_window #(
    .WIDTH    (WIDTH),
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk  (clk),
    .r_n  (r_n),
    .clr  (clr),
    .push (push),
    .din  (speed),
    .sum  (sum),
    .full (full)
  );

  // Minimum decision, sized to this instance's sample width.
  always_comb begin
    take_min = 1'b0;
    if (IGNORE_ZERO && (speed == {WIDTH{1'b0}})) begin
      take_min = 1'b0;
    end else begin
      take_min = ~min_valid_r | (speed < min_r);
    end
  end

  // Next-state values for the extreme trackers.
  always_comb begin
    max_nxt       = max_r;
    min_nxt       = min_r;
    min_valid_nxt = min_valid_r;
    if (push && (speed > max_r)) begin
      max_nxt = speed;
    end else begin
      max_nxt = max_r;
    end
    if (push && take_min) begin
      min_nxt       = speed;
      min_valid_nxt = 1'b1;
    end else begin
      min_nxt       = min_r;
      min_valid_nxt = min_valid_r;
    end
  end

  // Extreme tracker registers; clr restarts the trip.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      max_r       <= {WIDTH{1'b0}};
      min_r       <= {WIDTH{1'b0}};
      min_valid_r <= 1'b0;
    end else if (clr) begin
      max_r       <= {WIDTH{1'b0}};
      min_r       <= {WIDTH{1'b0}};
      min_valid_r <= 1'b0;
    end else begin
      max_r       <= max_nxt;
      min_r       <= min_nxt;
      min_valid_r <= min_valid_nxt;
    end
  end

  assign max_out   = max_r;
  assign min_out   = min_r;
  assign min_valid = min_valid_r;
  assign avg_out   = sum[SUM_W-1:WIN_LOG2];
  assign avg_valid = full;

endmodule
